uart_program_loader: RTL and testbench

Boot-time loader sitting upstream of the FPG8 core and its RAM. It receives a framed program image over the UART rx line and assembles big-endian 16-bit words. Each word is written into RAM through a dedicated write port, and the CPU is held in reset via cpu_hold until the load completes and the checksum verifies. On success it releases the core; on any error it keeps the core held and resynchronises to the next frame.

---
 rtl/uart_program_loader.sv | 193 +++++++++++++++++++
 tb/tb_uart_program_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Boot loader: 8N1 UART frames (A5, LEN, LEN words big-endian, CHK) written to RAM; core held until checksum verifies.
// RAM write lands one clk after the LO byte is received; there is no backpressure, and the RAM port must accept every strobe.
module uart_program_loader #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   MAX_LEN  = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR} state_e;

  // ---------------- RX deserializer ----------------
  logic            rx_meta_q, rx_sync_q, rx_last_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_vld, frame_err;
  logic [7:0]      byte_dat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_last_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_last_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_last_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_BIT) begin
        // A start bit that has gone high again by mid-bit was a glitch.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == FULL_BIT) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 1'b1;
      end
      RX_STOP: if (rx_cnt_q == FULL_BIT) begin
        rx_state_d = RX_IDLE;
        if (rx_sync_q) byte_vld  = 1'b1;
        else           frame_err = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign byte_dat = rx_shift_q;

  // ---------------- Frame FSM ----------------
  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            sum_q, sum_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  active;
  logic [15:0]           new_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      len_q   <= '0;
      hi_q    <= '0;
      sum_q   <= '0;
      wc_q    <= '0;
      to_q    <= '0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      sum_q   <= sum_d;
      wc_q    <= wc_d;
      to_q    <= to_d;
      w_en_q  <= w_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    sum_d   = sum_q;
    wc_d    = wc_q;
    to_d    = '0;
    w_en_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    new_len = {len_q[15:8], byte_dat};
    active  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA_HI) ||
              (state_q == DATA_LO) || (state_q == CHECK);
    if (active) to_d = byte_vld ? '0 : to_q + 1'b1;

    case (state_q)
      SYNC, ERROR: if (byte_vld && byte_dat == 8'hA5) begin
        state_d = LEN_HI;
        sum_d   = '0;
        wc_d    = '0;
      end
      LEN_HI: if (byte_vld) begin
        len_d[15:8] = byte_dat;
        sum_d       = sum_q + byte_dat;
        state_d     = LEN_LO;
      end
      LEN_LO: if (byte_vld) begin
        len_d = new_len;
        sum_d = sum_q + byte_dat;
        if ({1'b0, new_len} > MAX_LEN) state_d = ERROR;
        else if (new_len == 16'd0)     state_d = CHECK;
        else                           state_d = DATA_HI;
      end
      DATA_HI: if (byte_vld) begin
        hi_d    = byte_dat;
        sum_d   = sum_q + byte_dat;
        state_d = DATA_LO;
      end
      DATA_LO: if (byte_vld) begin
        w_en_d  = 1'b1;
        addr_d  = wc_q[ADDR_WIDTH-1:0];
        wdata_d = DATA_WIDTH'({hi_q, byte_dat});
        wc_d    = wc_q + 1'b1;
        sum_d   = sum_q + byte_dat;
        state_d = ((17'(wc_q) + 17'd1) == {1'b0, len_q}) ? CHECK : DATA_HI;
      end
      CHECK: if (byte_vld) state_d = (byte_dat == sum_q) ? DONE : ERROR;
      default: ;
    endcase

    // Line errors and byte-gap timeouts abort only a frame in progress.
    if (active && (frame_err || (!byte_vld && to_q == TW'(TIMEOUT_CYCLES)))) state_d = ERROR;
  end

  assign ram_w_en   = w_en_q;
  assign ram_addr   = addr_q;
  assign ram_w_data = wdata_q;
  assign cpu_hold   = (state_q != DONE);
  assign load_done  = (state_q == DONE);
  assign load_error = (state_q == ERROR);
  assign word_count = wc_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized frame stimulus; expected RAM writes queued by the stimulus and checked by an independent write monitor.
module tb_uart_program_loader;
  localparam int CPB = 16;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int TO  = 400;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          ram_w_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_w_data;
  logic          cpu_hold, load_done, load_error;
  logic [AW:0]   word_count;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ram_w_en(ram_w_en), .ram_addr(ram_addr),
    .ram_w_data(ram_w_data), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wc;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] words[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reset && ram_w_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", ram_addr, ram_w_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), e.addr);
        check("wr_data", 32'(ram_w_data), e.data);
        check("wr_count", 32'(word_count), e.wc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask

  // Sends a complete frame for the words queue; chk_xor != 0 corrupts the checksum.
  task automatic send_frame(input logic [7:0] chk_xor);
    logic [15:0] len;
    logic [7:0]  sum;
    len = 16'(words.size());
    sum = len[15:8] + len[7:0];
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back('{addr: 32'(i), data: 32'(words[i]), wc: 32'(i + 1)});
      sum = sum + words[i][15:8] + words[i][7:0];
    end
    send_byte(8'hA5, 1'b0);
    send_byte(len[15:8], 1'b0);
    send_byte(len[7:0], 1'b0);
    for (int i = 0; i < words.size(); i++) begin
      send_byte(words[i][15:8], 1'b0);
      send_byte(words[i][7:0], 1'b0);
    end
    send_byte(sum ^ chk_xor, 1'b0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  task automatic check_status(input string tag, input bit done, input bit err, input int wc);
    repeat (4) @(negedge clk);
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_error"}, 32'(load_error), 32'(err));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!done));
    check({tag, "_word_count"}, 32'(word_count), 32'(wc));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_en"}, 32'(ram_w_en), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_w_data"}, 32'(ram_w_data), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word frame with good checksum.
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    send_frame(8'h00);
    check_status("basic", 1'b1, 1'b0, 2);
    do_reset();

    // Bad checksum: writes still land, then error; a good frame recovers from ERROR.
    send_frame(8'h01);
    check_status("badchk", 1'b0, 1'b1, 2);
    rand_words(3);
    send_frame(8'h00);
    check_status("recover", 1'b1, 1'b0, 3);
    do_reset();

    // Junk before the sync byte, then an empty frame.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    words.delete();
    send_frame(8'h00);
    check_status("junk_len0", 1'b1, 1'b0, 0);
    do_reset();

    // Length one past capacity is rejected; exactly full capacity is accepted.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'(2 ** AW + 1), 1'b0);
    check_status("len_over", 1'b0, 1'b1, 0);
    rand_words(2 ** AW);
    send_frame(8'h00);
    check_status("len_max", 1'b1, 1'b0, 2 ** AW);
    do_reset();

    // Framing error on a LO byte: no write for that word.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    repeat (CPB) @(posedge clk);
    check_status("frame_err", 1'b0, 1'b1, 0);
    do_reset();

    // Quarter-bit low glitch mid-frame must not inject a byte.
    words.delete();
    words.push_back(16'h1234);
    exp_q.push_back('{addr: 32'd0, data: 32'h1234, wc: 32'd1});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'(8'h01 + 8'h12 + 8'h34), 1'b0);
    check_status("glitch", 1'b1, 1'b0, 1);
    do_reset();

    // Inter-byte timeout.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    repeat (20) @(negedge clk);
    check("timeout_early_error", 32'(load_error), 32'd0);
    repeat (TO + 20) @(negedge clk);
    check_status("timeout", 1'b0, 1'b1, 0);
    do_reset();

    // Asynchronous reset while waiting for the second word's HI byte.
    exp_q.push_back('{addr: 32'd0, data: 32'h1234, wc: 32'd1});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    repeat (4) @(negedge clk);
    check("midreset_pre_count", 32'(word_count), 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    check("midreset_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized frames, some with corrupted checksum.
    for (int k = 0; k < 4; k++) begin
      int  n;
      bit  bad;
      n   = $urandom_range(1, 2 ** AW);
      bad = ($urandom_range(0, 2) == 0);
      rand_words(n);
      send_frame(bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      check_status("rand", !bad, bad, n);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
